// File: rtl/checkpoint_store.sv
// Branch recovery checkpoint store: a circular buffer of rename snapshots that is kept current by commit/writeback merges.
// Optional CKPT_STATS_EN adds save/restore/drop event counters.
module checkpoint_store #(
  parameter int N_CKPT      = 4,
  parameter int N_ARCH_REGS = 32,
  parameter int N_PHYS_REGS = 128,
  parameter int PREG_W      = 7,
  parameter int ROB_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          save_valid,
  output logic                          save_ready,
  input  logic [ROB_W-1:0]              save_rob_tag,
  input  logic [N_ARCH_REGS*PREG_W-1:0] save_rat,
  input  logic [N_PHYS_REGS-1:0]        save_freelist,
  input  logic [N_PHYS_REGS-1:0]        save_prf_valid,
  input  logic [2*ROB_W:0]              save_rob_ptrs,
  input  logic [ROB_W-1:0]              save_tag_ctr,
  input  logic                          resolve_valid,
  input  logic [ROB_W-1:0]              resolve_rob_tag,
  input  logic                          resolve_mispredict,
  input  logic                          commit_free_valid,
  input  logic [PREG_W-1:0]             commit_free_preg,
  input  logic                          wb_valid,
  input  logic [PREG_W-1:0]             wb_preg,
  input  logic                          flush,
  output logic                          restore_valid,
  output logic [N_ARCH_REGS*PREG_W-1:0] restore_rat,
  output logic [N_PHYS_REGS-1:0]        restore_freelist,
  output logic [N_PHYS_REGS-1:0]        restore_prf_valid,
  output logic [2*ROB_W:0]              restore_rob_ptrs,
  output logic [ROB_W-1:0]              restore_tag_ctr,
  output logic [$clog2(N_CKPT):0]       ckpt_count
`ifdef CKPT_STATS_EN
  ,
  output logic [31:0]                   stat_saves,
  output logic [31:0]                   stat_restores,
  output logic [31:0]                   stat_drops
`endif
);

  localparam int IDX_W = $clog2(N_CKPT);
  localparam int CNT_W = IDX_W + 1;
  localparam int PTR_W = 2 * ROB_W + 1;
  localparam int RAT_W = N_ARCH_REGS * PREG_W;

  logic                   valid_reg    [N_CKPT];
  logic [ROB_W-1:0]       tag_reg      [N_CKPT];
  logic [N_PHYS_REGS-1:0] freelist_reg [N_CKPT];
  logic [N_PHYS_REGS-1:0] prf_reg      [N_CKPT];
  logic [RAT_W-1:0]       rat_mem      [N_CKPT];
  logic [PTR_W-1:0]       ptrs_mem     [N_CKPT];
  logic [ROB_W-1:0]       tag_ctr_mem  [N_CKPT];

  logic [IDX_W-1:0] head_reg;
  logic [IDX_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic [N_CKPT-1:0]      match_vec;
  logic [N_CKPT-1:0]      kill_vec;
  logic [IDX_W-1:0]       match_idx;
  logic                   hit;
  logic [IDX_W-1:0]       keep_depth;
  logic [N_PHYS_REGS-1:0] free_onehot;
  logic [N_PHYS_REGS-1:0] wb_onehot;
  logic                   do_restore;
  logic                   do_release;
  logic                   do_save;
  logic                   do_retire;

  assign save_ready  = (count_reg < CNT_W'(N_CKPT));
  assign ckpt_count  = count_reg;
  assign free_onehot = commit_free_valid ? (N_PHYS_REGS'(1) << commit_free_preg) : '0;
  assign wb_onehot   = wb_valid ? (N_PHYS_REGS'(1) << wb_preg) : '0;

  always_comb begin
    match_idx = '0;
    for (int j = 0; j < N_CKPT; j++) begin
      if (match_vec[j]) match_idx = IDX_W'(j);
    end
  end

  assign hit        = |match_vec;
  // Slots at or beyond the restored one (in age order from head) are discarded.
  assign keep_depth = match_idx - head_reg;
  assign do_restore = resolve_valid && resolve_mispredict && hit && !flush;
  assign do_release = resolve_valid && !resolve_mispredict && hit && !flush;
  assign do_save    = save_valid && save_ready && !flush && !do_restore;
  assign do_retire  = (count_reg != '0) && !valid_reg[head_reg] && !flush && !do_restore;

  generate
    for (genvar gi = 0; gi < N_CKPT; gi++) begin : g_slot
      logic [IDX_W-1:0] age_offset;
      logic             write_here;

      assign age_offset    = IDX_W'(gi) - head_reg;
      assign kill_vec[gi]  = (age_offset >= keep_depth);
      assign match_vec[gi] = valid_reg[gi] && (tag_reg[gi] == resolve_rob_tag);
      assign write_here    = do_save && (tail_reg == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          tag_reg[gi]   <= '0;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (do_restore && kill_vec[gi]) begin
          valid_reg[gi] <= 1'b0;
        end else if (write_here) begin
          valid_reg[gi] <= 1'b1;
          tag_reg[gi]   <= save_rob_tag;
        end else if (do_release && (match_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      // A freshly saved snapshot picks up this cycle's commit/writeback too.
      always_ff @(posedge clk) begin
        if (write_here) begin
          freelist_reg[gi] <= save_freelist | free_onehot;
          prf_reg[gi]      <= save_prf_valid | wb_onehot;
        end else if (valid_reg[gi]) begin
          freelist_reg[gi] <= freelist_reg[gi] | free_onehot;
          prf_reg[gi]      <= prf_reg[gi] | wb_onehot;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (do_save) begin
      rat_mem[tail_reg]     <= save_rat;
      ptrs_mem[tail_reg]    <= save_rob_ptrs;
      tag_ctr_mem[tail_reg] <= save_tag_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (do_restore) begin
      tail_reg  <= match_idx;
      count_reg <= CNT_W'(keep_depth);
    end else begin
      if (do_save)   tail_reg <= tail_reg + 1'b1;
      if (do_retire) head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_save) - CNT_W'(do_retire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      restore_valid     <= 1'b0;
      restore_rat       <= '0;
      restore_freelist  <= '0;
      restore_prf_valid <= '0;
      restore_rob_ptrs  <= '0;
      restore_tag_ctr   <= '0;
    end else begin
      restore_valid <= do_restore;
      if (do_restore) begin
        restore_rat       <= rat_mem[match_idx];
        restore_freelist  <= freelist_reg[match_idx] | free_onehot;
        restore_prf_valid <= prf_reg[match_idx] | wb_onehot;
        restore_rob_ptrs  <= ptrs_mem[match_idx];
        restore_tag_ctr   <= tag_ctr_mem[match_idx];
      end
    end
  end

`ifdef CKPT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_saves    <= '0;
      stat_restores <= '0;
      stat_drops    <= '0;
    end else begin
      if (do_save)                   stat_saves    <= stat_saves + 32'd1;
      if (do_restore)                stat_restores <= stat_restores + 32'd1;
      if (save_valid && !save_ready) stat_drops    <= stat_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_checkpoint_store.sv
// Directed self-checking bench for checkpoint_store: fill/release, out-of-order release, trim, merge, collisions, wrap.
module tb_checkpoint_store;

  logic         clk = 1'b0;
  logic         rst;
  logic         save_valid;
  logic         save_ready;
  logic [3:0]   save_rob_tag;
  logic [223:0] save_rat;
  logic [127:0] save_freelist;
  logic [127:0] save_prf_valid;
  logic [8:0]   save_rob_ptrs;
  logic [3:0]   save_tag_ctr;
  logic         resolve_valid;
  logic [3:0]   resolve_rob_tag;
  logic         resolve_mispredict;
  logic         commit_free_valid;
  logic [6:0]   commit_free_preg;
  logic         wb_valid;
  logic [6:0]   wb_preg;
  logic         flush;
  logic         restore_valid;
  logic [223:0] restore_rat;
  logic [127:0] restore_freelist;
  logic [127:0] restore_prf_valid;
  logic [8:0]   restore_rob_ptrs;
  logic [3:0]   restore_tag_ctr;
  logic [2:0]   ckpt_count;
`ifdef CKPT_STATS_EN
  logic [31:0]  stat_saves;
  logic [31:0]  stat_restores;
  logic [31:0]  stat_drops;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  checkpoint_store dut (
    .clk(clk), .rst(rst),
    .save_valid(save_valid), .save_ready(save_ready), .save_rob_tag(save_rob_tag),
    .save_rat(save_rat), .save_freelist(save_freelist), .save_prf_valid(save_prf_valid),
    .save_rob_ptrs(save_rob_ptrs), .save_tag_ctr(save_tag_ctr),
    .resolve_valid(resolve_valid), .resolve_rob_tag(resolve_rob_tag),
    .resolve_mispredict(resolve_mispredict),
    .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .flush(flush),
    .restore_valid(restore_valid), .restore_rat(restore_rat),
    .restore_freelist(restore_freelist), .restore_prf_valid(restore_prf_valid),
    .restore_rob_ptrs(restore_rob_ptrs), .restore_tag_ctr(restore_tag_ctr),
    .ckpt_count(ckpt_count)
`ifdef CKPT_STATS_EN
    , .stat_saves(stat_saves), .stat_restores(stat_restores), .stat_drops(stat_drops)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic set_save(input logic [3:0] tag, input logic [6:0] r5);
    save_valid    = 1'b1;
    save_rob_tag  = tag;
    save_rat      = '0;
    save_rat[5*7 +: 7] = r5;
    save_rob_ptrs = 9'(tag) * 9'd3;
    save_tag_ctr  = tag + 4'd1;
  endtask

  task automatic do_save(input logic [3:0] tag, input logic [6:0] r5);
    set_save(tag, r5);
    tick();
    save_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic [3:0] tag, input logic mp);
    resolve_valid      = 1'b1;
    resolve_rob_tag    = tag;
    resolve_mispredict = mp;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; save_valid = 1'b0; save_rob_tag = '0; save_rat = '0;
    save_freelist = '0; save_prf_valid = '0; save_rob_ptrs = '0; save_tag_ctr = '0;
    resolve_valid = 1'b0; resolve_rob_tag = '0; resolve_mispredict = 1'b0;
    commit_free_valid = 1'b0; commit_free_preg = '0; wb_valid = 1'b0; wb_preg = '0;
    flush = 1'b0;
    tick(); tick();
    chk("reset_count", 32'(ckpt_count), 32'd0);
    chk("reset_ready", 32'(save_ready), 32'd1);
    chk("reset_rvalid", 32'(restore_valid), 32'd0);
    chk("reset_rat5", 32'(restore_rat[5*7 +: 7]), 32'd0);
    rst = 1'b0;

    // Fill and release
    for (int t = 1; t <= 4; t++) do_save(4'(t), 7'(t));
    chk("fill_count", 32'(ckpt_count), 32'd4);
    chk("fill_ready", 32'(save_ready), 32'd0);
    do_save(4'd5, 7'd5);
    chk("drop_count", 32'(ckpt_count), 32'd4);
    do_resolve(4'd1, 1'b0);
    chk("release_same_cycle_count", 32'(ckpt_count), 32'd4);
    tick();
    chk("release_retire_count", 32'(ckpt_count), 32'd3);
    chk("release_retire_ready", 32'(save_ready), 32'd1);
    do_flush();
    chk("flush_count", 32'(ckpt_count), 32'd0);

    // Out-of-order release
    for (int t = 1; t <= 3; t++) do_save(4'(t), 7'(t));
    do_resolve(4'd2, 1'b0);
    tick();
    chk("ooo_hole_count", 32'(ckpt_count), 32'd3);
    do_resolve(4'd1, 1'b0);
    tick();
    chk("ooo_skip1_count", 32'(ckpt_count), 32'd2);
    tick();
    chk("ooo_skip2_count", 32'(ckpt_count), 32'd1);
    do_flush();

    // Mispredict trim
    do_save(4'd1, 7'd9); do_save(4'd2, 7'd10); do_save(4'd3, 7'd11);
    do_resolve(4'd2, 1'b1);
    chk("trim_rvalid", 32'(restore_valid), 32'd1);
    chk("trim_rat5", 32'(restore_rat[5*7 +: 7]), 32'd10);
    chk("trim_ptrs", 32'(restore_rob_ptrs), 32'd6);
    chk("trim_tagctr", 32'(restore_tag_ctr), 32'd3);
    chk("trim_count", 32'(ckpt_count), 32'd1);
    do_resolve(4'd3, 1'b1);
    chk("trim_younger_gone", 32'(restore_valid), 32'd0);
    chk("trim_hold_rat5", 32'(restore_rat[5*7 +: 7]), 32'd10);
    do_save(4'd4, 7'd12);
    chk("trim_refill_count", 32'(ckpt_count), 32'd2);
    do_resolve(4'd4, 1'b1);
    chk("trim_tail_slot1_rat5", 32'(restore_rat[5*7 +: 7]), 32'd12);
    chk("trim_tail_slot1_count", 32'(ckpt_count), 32'd1);
    do_flush();

    // Merge into resident snapshot
    do_save(4'd7, 7'd7);
    commit_free_valid = 1'b1; commit_free_preg = 7'd40; tick(); commit_free_valid = 1'b0;
    wb_valid = 1'b1; wb_preg = 7'd50; tick(); wb_valid = 1'b0;
    do_resolve(4'd7, 1'b1);
    chk("merge_free40", 32'(restore_freelist[40]), 32'd1);
    chk("merge_free41", 32'(restore_freelist[41]), 32'd0);
    chk("merge_prf50", 32'(restore_prf_valid[50]), 32'd1);
    chk("merge_count", 32'(ckpt_count), 32'd0);
    // Save with same-cycle writeback, restore with same-cycle commit free
    set_save(4'd8, 7'd8); wb_valid = 1'b1; wb_preg = 7'd70;
    tick();
    save_valid = 1'b0; wb_valid = 1'b0;
    commit_free_valid = 1'b1; commit_free_preg = 7'd60;
    do_resolve(4'd8, 1'b1);
    commit_free_valid = 1'b0;
    chk("merge_save_wb70", 32'(restore_prf_valid[70]), 32'd1);
    chk("merge_restore_free60", 32'(restore_freelist[60]), 32'd1);
    chk("merge_fresh_prf50", 32'(restore_prf_valid[50]), 32'd0);

    // Simultaneous events
    do_save(4'd3, 7'd3);
    set_save(4'd9, 7'd9);
    do_resolve(4'd3, 1'b1);
    save_valid = 1'b0;
    chk("sim_restore_rvalid", 32'(restore_valid), 32'd1);
    chk("sim_restore_rat5", 32'(restore_rat[5*7 +: 7]), 32'd3);
    chk("sim_save_dropped_count", 32'(ckpt_count), 32'd0);
    do_resolve(4'd9, 1'b1);
    chk("sim_tag9_absent", 32'(restore_valid), 32'd0);
    do_save(4'd5, 7'd5);
    flush = 1'b1;
    do_resolve(4'd5, 1'b1);
    flush = 1'b0;
    chk("flush_mp_rvalid", 32'(restore_valid), 32'd0);
    chk("flush_mp_count", 32'(ckpt_count), 32'd0);
    chk("flush_mp_hold_rat5", 32'(restore_rat[5*7 +: 7]), 32'd3);

    // Wrap-around
    for (int k = 1; k <= 10; k++) begin
      do_save(4'(k), 7'(k));
      do_resolve(4'(k), 1'b0);
    end
    chk("wrap_loop_count", 32'(ckpt_count), 32'd1);
    tick();
    chk("wrap_drained_count", 32'(ckpt_count), 32'd0);
    do_save(4'd11, 7'd11); do_save(4'd12, 7'd12);
    chk("wrap_two_count", 32'(ckpt_count), 32'd2);
    do_resolve(4'd12, 1'b1);
    chk("wrap_mp_rvalid", 32'(restore_valid), 32'd1);
    chk("wrap_mp_rat5", 32'(restore_rat[5*7 +: 7]), 32'd12);
    chk("wrap_mp_count", 32'(ckpt_count), 32'd1);
    tick();
    chk("wrap_pulse_ends", 32'(restore_valid), 32'd0);
    do_save(4'd13, 7'd13);
    do_resolve(4'd13, 1'b1);
    chk("wrap_tail3_rat5", 32'(restore_rat[5*7 +: 7]), 32'd13);
    chk("wrap_tail3_count", 32'(ckpt_count), 32'd1);

    // Reset mid-restore
    do_save(4'd1, 7'd1);
    rst = 1'b1;
    do_resolve(4'd1, 1'b1);
    rst = 1'b0;
    chk("rst_mid_rvalid", 32'(restore_valid), 32'd0);
    chk("rst_mid_rat5", 32'(restore_rat[5*7 +: 7]), 32'd0);
    chk("rst_mid_count", 32'(ckpt_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
